// File: rtl/stream_packet_receiver.sv
// Receive endpoint for UID-addressed packets: filters on destination UID, strips the
// header, forwards payload through a single output register and keeps traffic counters.
module stream_packet_receiver #(
    parameter logic [7:0]  LOCAL_UID   = 8'h02,
    parameter logic [7:0]  BCAST_UID   = 8'hFF,
    parameter int unsigned MAX_PAYLOAD = 1024
) (
    input  logic        clk_200MHz,
    input  logic        peripheral_reset,
    input  logic [31:0] s_tdata,
    input  logic        s_tlast,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic [31:0] m_tdata,
    output logic        m_tlast,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [7:0]  m_tuser,
    output logic        pkt_done,
    output logic [15:0] pkt_len,
    output logic        err_pulse,
    output logic [1:0]  err_code,
    output logic [15:0] acc_cnt,
    output logic [15:0] drop_cnt
);

    typedef enum logic [1:0] {HEADER, PASS, DROP} state_t;

    localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

    state_t      state, state_next;
    logic [15:0] cnt;
    logic [15:0] cnt_inc;
    logic [15:0] beat_len;
    logic [7:0]  pend_uid;
    logic        uid_match;
    logic        pass_ready;
    logic        out_hs;
    logic        load;
    logic        hdr_take;
    logic        ev_accept;
    logic        ev_drop;
    logic        ev_empty;
    logic        ev_overlen;

    assign cnt_inc    = cnt + 16'd1;
    assign uid_match  = (s_tdata[31:24] == LOCAL_UID) || (s_tdata[31:24] == BCAST_UID);
    assign pass_ready = !m_tvalid || m_tready;
    assign out_hs     = m_tvalid && m_tready;

    always_ff @(posedge clk_200MHz or posedge peripheral_reset) begin
        if (peripheral_reset) state <= HEADER;
        else                  state <= state_next;
    end

    always_comb begin
        state_next = state;
        s_tready   = 1'b1;
        load       = 1'b0;
        hdr_take   = 1'b0;
        ev_accept  = 1'b0;
        ev_drop    = 1'b0;
        ev_empty   = 1'b0;
        ev_overlen = 1'b0;
        case (state)
            HEADER: begin
                if (s_tvalid) begin
                    if (s_tlast) begin
                        ev_empty = 1'b1;
                        ev_drop  = 1'b1;
                    end else if (uid_match) begin
                        hdr_take   = 1'b1;
                        state_next = PASS;
                    end else begin
                        ev_drop    = 1'b1;
                        state_next = DROP;
                    end
                end
            end
            PASS: begin
                s_tready = pass_ready;
                if (s_tvalid && pass_ready) begin
                    load = 1'b1;
                    if (s_tlast) begin
                        ev_accept  = 1'b1;
                        state_next = HEADER;
                    end else if (cnt_inc == MAX_LEN) begin
                        ev_accept  = 1'b1;
                        ev_overlen = 1'b1;
                        state_next = DROP;
                    end
                end
            end
            DROP: begin
                if (s_tvalid && s_tlast) state_next = HEADER;
            end
            default: state_next = HEADER;
        endcase
    end

    // TX_UID waits in pend_uid so the previous packet's m_tuser survives until it drains.
    always_ff @(posedge clk_200MHz or posedge peripheral_reset) begin
        if (peripheral_reset) begin
            m_tvalid  <= 1'b0;
            m_tdata   <= '0;
            m_tlast   <= 1'b0;
            m_tuser   <= '0;
            pend_uid  <= '0;
            beat_len  <= '0;
            cnt       <= '0;
            pkt_done  <= 1'b0;
            pkt_len   <= '0;
            err_pulse <= 1'b0;
            err_code  <= '0;
            acc_cnt   <= '0;
            drop_cnt  <= '0;
        end else begin
            if (hdr_take) begin
                pend_uid <= s_tdata[23:16];
                cnt      <= '0;
            end
            if (load) begin
                m_tvalid <= 1'b1;
                m_tdata  <= s_tdata;
                m_tlast  <= s_tlast || (cnt_inc == MAX_LEN);
                m_tuser  <= pend_uid;
                beat_len <= cnt_inc;
                cnt      <= cnt_inc;
            end else if (out_hs) begin
                m_tvalid <= 1'b0;
            end
            pkt_done <= out_hs && m_tlast;
            if (out_hs && m_tlast) pkt_len <= beat_len;
            err_pulse <= ev_empty || ev_overlen;
            if (ev_empty)        err_code <= 2'd1;
            else if (ev_overlen) err_code <= 2'd2;
            if (ev_accept) acc_cnt  <= acc_cnt + 16'd1;
            if (ev_drop)   drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule
